video_timing_gen: RTL

Generates raster timing for the HDMI/DVI output path: pixel/line counters, hsync/vsync, video-data-enable and frame/line markers. Sits directly upstream of the three TMDS encoder channels. vde drives every encoder's VDE input, cd drives the blue channel's CD input ({vsync,hsync}), and x/y address the pattern/pixel source. Pixel rate is set by a clock-enable, so the block runs on the encoder clock domain.

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/video_timing_gen_axis_counter.sv | 30 +++
 rtl/video_timing_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
package video_timing_pkg;

  // Default 640x480@60 timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP; // 800
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP; // 525
  localparam int DEF_CW       = 10;

  // Sync polarity: value of the sync line while it is asserted
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Smallest counter width able to hold 0..max(h_total,v_total)-1
  function automatic int counter_width(input int h_total, input int v_total);
    int m;
    m = (h_total > v_total) ? h_total : v_total;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// Wrap-at-TOTAL counter with enable; wrap is high on the enabled terminal count.
module video_axis_counter #(
  parameter int CW    = 10,
  parameter int TOTAL = 800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] count_reg;

  assign count = count_reg;
  assign wrap  = en && (count_reg == LAST);

  // Advance on enable, returning to zero after the last position
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (en) begin
      if (count_reg == LAST) count_reg <= '0;
      else                   count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with registered sync/vde/marker decode.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic VS_POL   = SYNC_ACTIVE_LOW,
  parameter int   CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic          vde,
  output logic          hsync,
  output logic          vsync,
  output logic [1:0]    cd,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Refuse to build if the counters cannot reach the last position
  if (CW < counter_width(H_TOTAL, V_TOTAL)) begin : g_cw_check
    $fatal(1, "video_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_B  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_E  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_B  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_E  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          h_wrap;
  logic          v_wrap_unused;

  video_axis_counter #(.CW(CW), .TOTAL(H_TOTAL)) u_h_counter (
    .clk   (clk),
    .reset (reset),
    .en    (ce),
    .count (hcount),
    .wrap  (h_wrap)
  );

  // Lines advance only when the pixel counter wraps
  video_axis_counter #(.CW(CW), .TOTAL(V_TOTAL)) u_v_counter (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (vcount),
    .wrap  (v_wrap_unused)
  );

  // Combinational decode of the current counter position
  logic vde_next;
  logic hsync_next;
  logic vsync_next;
  logic line_start_next;
  logic frame_start_next;

  // Decode position into active/sync/marker levels
  always_comb begin
    vde_next         = (hcount < H_ACT_END) && (vcount < V_ACT_END);
    hsync_next       = ((hcount >= H_SYNC_B) && (hcount < H_SYNC_E)) ? HS_POL : ~HS_POL;
    vsync_next       = ((vcount >= V_SYNC_B) && (vcount < V_SYNC_E)) ? VS_POL : ~VS_POL;
    line_start_next  = (hcount == '0);
    frame_start_next = (hcount == '0) && (vcount == '0);
  end

  logic          vde_reg;
  logic          hsync_reg;
  logic          vsync_reg;
  logic [CW-1:0] x_reg;
  logic [CW-1:0] y_reg;
  logic          line_start_reg;
  logic          frame_start_reg;

  // Register the decode on each pixel strobe; levels hold and pulses drop otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      vde_reg         <= 1'b0;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      x_reg           <= '0;
      y_reg           <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (ce) begin
      vde_reg         <= vde_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      x_reg           <= hcount;
      y_reg           <= vcount;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign vde         = vde_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign cd          = {vsync_reg, hsync_reg};
  assign x           = x_reg;
  assign y           = y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule
